// File: rtl/bcd_serial_add_ctrl.sv
// Serial BCD add controller: drives one shared single-digit BCD adder,
// one digit per clock, least significant digit first.
module bcd_serial_add_ctrl #(
    parameter int DIGITS = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [4*DIGITS-1:0] op_a,
    input  logic [4*DIGITS-1:0] op_b,
    input  logic              cin,
    output logic              busy,
    output logic              done,
    output logic [4*DIGITS-1:0] sum,
    output logic              cout,
    output logic              err,
    output logic [3:0]        add_a,
    output logic [3:0]        add_b,
    output logic              add_ci,
    input  logic [3:0]        add_s,
    input  logic              add_co
);

    localparam int W  = 4 * DIGITS;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state, state_nxt;
    logic [W-1:0]    a_q, b_q;
    logic            carry;
    logic [IW-1:0]   idx;
    logic            last;
    logic            bad;

    assign last = (idx == IW'(DIGITS - 1));

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state and handshake outputs; done and busy are mutually exclusive by state
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: if (start) state_nxt = RUN;
            RUN: begin
                busy = 1'b1;
                if (last) state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Present the current digit pair to the external adder; quiet outside RUN
    always_comb begin
        add_a  = 4'd0;
        add_b  = 4'd0;
        add_ci = 1'b0;
        if (state == RUN) begin
            add_ci = carry;
            for (int i = 0; i < DIGITS; i++) begin
                if (idx == IW'(i)) begin
                    add_a = a_q[4*i +: 4];
                    add_b = b_q[4*i +: 4];
                end
            end
        end
    end

    // Flag any non-decimal nibble on the incoming operands
    always_comb begin
        bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (op_a[4*i +: 4] > 4'd9 || op_b[4*i +: 4] > 4'd9) bad = 1'b1;
        end
    end

    // Operand latch, digit capture and carry chain
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q   <= '0;
            b_q   <= '0;
            carry <= 1'b0;
            idx   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            err   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    a_q   <= op_a;
                    b_q   <= op_b;
                    carry <= cin;
                    idx   <= '0;
                    sum   <= '0;
                    cout  <= 1'b0;
                    err   <= bad;
                end
                RUN: begin
                    for (int i = 0; i < DIGITS; i++) begin
                        if (idx == IW'(i)) sum[4*i +: 4] <= add_s;
                    end
                    carry <= add_co;
                    // idx stops at the last digit; the FSM leaves RUN on this edge
                    if (last) cout <= add_co;
                    else      idx  <= idx + IW'(1);
                end
                default: ;
            endcase
        end
    end

endmodule
